// File: rtl/wb_rst_sequencer_pkg.sv
// Shared definitions for the staged Wishbone reset sequencer.
//   seq_state_t : sequencer state encoding (3-bit)
//   LOCK_CNT_W  : width of the lock-loss event counter
//   clog2       : counter width able to hold 0..value-1 (minimum 1 bit)
package wb_rst_sequencer_pkg;

   localparam int unsigned LOCK_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_SOFT      = 3'd4
   } seq_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/wb_rst_sequencer_sync_2ff.sv
// Two-flop synchronizer for slow CDC control bits, with synchronous clear.
//   clk : destination clock
//   clr : synchronous active-high clear of both flop stages
//   d   : asynchronous input bits
//   q   : synchronized output bits
module wb_rst_sequencer_sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (clr) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/wb_rst_sequencer.sv
// Staged reset sequencer in the Wishbone clock domain. Qualifies the DCM lock,
// releases per-subsystem resets one at a time STAGE_GAP cycles apart, and
// re-runs the sequence after lock loss or a soft reset request.
//   WB_CLK        : Wishbone clock
//   WB_RST        : synchronous active-high reset
//   LOCKED_IN     : DCM lock, asynchronous to WB_CLK
//   SOFT_RST_REQ  : single-cycle soft reset request
//   RST_OUT       : active-high stage resets, bit 0 released first
//   SEQ_DONE      : high while all stages are released
//   LOCK_LOST     : one-cycle pulse per counted lock loss
//   LOCK_LOSS_CNT : saturating lock-loss count
module wb_rst_sequencer
   import wb_rst_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned STAGE_GAP   = 16,
   parameter int unsigned LOCK_STABLE = 64,
   parameter int unsigned SOFT_HOLD   = 32
) (
   input  logic                  WB_CLK,
   input  logic                  WB_RST,
   input  logic                  LOCKED_IN,
   input  logic                  SOFT_RST_REQ,
   output logic [NUM_STAGES-1:0] RST_OUT,
   output logic                  SEQ_DONE,
   output logic                  LOCK_LOST,
   output logic [LOCK_CNT_W-1:0] LOCK_LOSS_CNT
);

   localparam int unsigned STABLE_W   = clog2(LOCK_STABLE);
   localparam int unsigned GAP_W      = clog2(STAGE_GAP);
   localparam int unsigned STAGE_W    = clog2(NUM_STAGES);
   localparam int unsigned HOLD_W     = clog2(SOFT_HOLD);
   // stage_cnt value on the edge that clears the final bit
   localparam int unsigned LAST_STAGE = (NUM_STAGES > 1) ? NUM_STAGES - 2 : 0;
   localparam logic [LOCK_CNT_W-1:0] CNT_MAX = '1;

   seq_state_t          state;
   logic                lock_s;
   logic [STABLE_W-1:0] stable_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic [STAGE_W-1:0]  stage_cnt;
   logic [HOLD_W-1:0]   hold_cnt;

   // Lock synchronizer
   wb_rst_sequencer_sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk (WB_CLK),
      .clr (WB_RST),
      .d   (LOCKED_IN),
      .q   (lock_s)
   );

   // Sequencer FSM, counters and registered outputs.
   // RST_OUT starts all ones and shifts left, so bit 0 clears first.
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         state         <= ST_IDLE;
         RST_OUT       <= '1;
         SEQ_DONE      <= 1'b0;
         LOCK_LOST     <= 1'b0;
         LOCK_LOSS_CNT <= '0;
         stable_cnt    <= '0;
         gap_cnt       <= '0;
         stage_cnt     <= '0;
         hold_cnt      <= '0;
      end else begin
         LOCK_LOST <= 1'b0;
         case (state)
            ST_IDLE: begin
               state <= ST_WAIT_LOCK;
            end

            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  stable_cnt <= '0;
               end else if (stable_cnt == STABLE_W'(LOCK_STABLE - 1)) begin
                  RST_OUT    <= RST_OUT << 1;
                  stable_cnt <= '0;
                  gap_cnt    <= '0;
                  stage_cnt  <= '0;
                  if (NUM_STAGES == 1) begin
                     SEQ_DONE <= 1'b1;
                     state    <= ST_RUN;
                  end else begin
                     state    <= ST_RELEASE;
                  end
               end else begin
                  stable_cnt <= stable_cnt + STABLE_W'(1);
               end
            end

            ST_RELEASE, ST_RUN: begin
               // Lock loss takes priority over a simultaneous soft request
               if (!lock_s) begin
                  RST_OUT    <= '1;
                  SEQ_DONE   <= 1'b0;
                  LOCK_LOST  <= 1'b1;
                  if (LOCK_LOSS_CNT != CNT_MAX)
                     LOCK_LOSS_CNT <= LOCK_LOSS_CNT + LOCK_CNT_W'(1);
                  stable_cnt <= '0;
                  gap_cnt    <= '0;
                  stage_cnt  <= '0;
                  state      <= ST_WAIT_LOCK;
               end else if (SOFT_RST_REQ) begin
                  RST_OUT    <= '1;
                  SEQ_DONE   <= 1'b0;
                  stable_cnt <= '0;
                  gap_cnt    <= '0;
                  stage_cnt  <= '0;
                  hold_cnt   <= '0;
                  state      <= ST_SOFT;
               end else if (state == ST_RELEASE) begin
                  if (gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
                     gap_cnt   <= '0;
                     RST_OUT   <= RST_OUT << 1;
                     stage_cnt <= stage_cnt + STAGE_W'(1);
                     if (stage_cnt == STAGE_W'(LAST_STAGE)) begin
                        SEQ_DONE <= 1'b1;
                        state    <= ST_RUN;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
            end

            ST_SOFT: begin
               if (hold_cnt == HOLD_W'(SOFT_HOLD - 1)) begin
                  hold_cnt   <= '0;
                  stable_cnt <= '0;
                  state      <= ST_WAIT_LOCK;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rst_sequencer.sv
// Self-checking bench for wb_rst_sequencer with default parameters.
// Expected output snapshots are queued with the absolute edge number at which
// they must be visible and compared on the following falling edge.
module tb_wb_rst_sequencer;

   logic       WB_CLK = 1'b0;
   logic       WB_RST;
   logic       LOCKED_IN;
   logic       SOFT_RST_REQ;
   logic [3:0] RST_OUT;
   logic       SEQ_DONE;
   logic       LOCK_LOST;
   logic [7:0] LOCK_LOSS_CNT;

   typedef struct {
      int         edge_n;
      logic [3:0] rst;
      logic       done;
      logic       lost;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_cnt  = 0;

   wb_rst_sequencer dut (
      .WB_CLK        (WB_CLK),
      .WB_RST        (WB_RST),
      .LOCKED_IN     (LOCKED_IN),
      .SOFT_RST_REQ  (SOFT_RST_REQ),
      .RST_OUT       (RST_OUT),
      .SEQ_DONE      (SEQ_DONE),
      .LOCK_LOST     (LOCK_LOST),
      .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
   );

   always #5 WB_CLK = ~WB_CLK;

   always @(posedge WB_CLK) cyc <= cyc + 1;

   function automatic void push(input int e, input logic [3:0] r, input logic d,
                                input logic l, input int c, input string tag);
      exp_t x;
      x.edge_n = e; x.rst = r; x.done = d; x.lost = l; x.cnt = 8'(c); x.tag = tag;
      sb.push_back(x);
   endfunction

   task automatic test_reset();
      WB_RST = 1'b1; LOCKED_IN = 1'b1; SOFT_RST_REQ = 1'b0;
      repeat (3) @(negedge WB_CLK);
      n_checks++;
      if (RST_OUT !== 4'hF || SEQ_DONE !== 1'b0) begin
         $display("FAIL reset_stages: rst=%h done=%b, required rst=f done=0", RST_OUT, SEQ_DONE);
      end else n_pass++;
      n_checks++;
      if (LOCK_LOST !== 1'b0 || LOCK_LOSS_CNT !== 8'd0) begin
         $display("FAIL reset_status: lost=%b cnt=%0d, required lost=0 cnt=0", LOCK_LOST, LOCK_LOSS_CNT);
      end else n_pass++;
   endtask

   task automatic test_power_up();
      int   b;
      int   guard;
      exp_t e;
      WB_RST = 1'b0;
      b = cyc;
      push(b + 2,   4'hF, 0, 0, exp_cnt, "pu_e2");
      push(b + 65,  4'hF, 0, 0, exp_cnt, "pu_e65");
      push(b + 66,  4'hE, 0, 0, exp_cnt, "pu_e66");
      push(b + 81,  4'hE, 0, 0, exp_cnt, "pu_e81");
      push(b + 82,  4'hC, 0, 0, exp_cnt, "pu_e82");
      push(b + 98,  4'h8, 0, 0, exp_cnt, "pu_e98");
      push(b + 113, 4'h8, 0, 0, exp_cnt, "pu_e113");
      push(b + 114, 4'h0, 1, 0, exp_cnt, "pu_e114");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      if (sb.size() > 0) begin n_checks++; $display("FAIL pu_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_lock_loss();
      int   c0;
      int   guard;
      exp_t e;
      c0 = cyc;
      LOCKED_IN = 1'b0;
      push(c0 + 2, 4'h0, 1, 0, exp_cnt, "ll_pre");
      exp_cnt++;
      push(c0 + 3, 4'hF, 0, 1, exp_cnt, "ll_pulse");
      push(c0 + 4, 4'hF, 0, 0, exp_cnt, "ll_post");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      repeat (6) @(negedge WB_CLK);
      LOCKED_IN = 1'b1;
      push(c0 + 75,  4'hF, 0, 0, exp_cnt, "ll_requal");
      push(c0 + 76,  4'hE, 0, 0, exp_cnt, "ll_stage0");
      push(c0 + 124, 4'h0, 1, 0, exp_cnt, "ll_done");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      if (sb.size() > 0) begin n_checks++; $display("FAIL ll_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   // Mid-run WB_RST clears the count, then a one-cycle lock glitch at stable count 40
   task automatic test_glitch();
      int   c;
      int   b;
      int   guard;
      exp_t e;
      c = cyc;
      WB_RST = 1'b1;
      exp_cnt = 0;
      push(c + 1, 4'hF, 0, 0, exp_cnt, "gl_wbrst");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      repeat (2) @(negedge WB_CLK);
      WB_RST = 1'b0;
      b = cyc;
      push(b + 66,  4'hF, 0, 0, exp_cnt, "gl_no_e66");
      push(b + 106, 4'hF, 0, 0, exp_cnt, "gl_e106");
      push(b + 107, 4'hE, 0, 0, exp_cnt, "gl_e107");
      push(b + 155, 4'h0, 1, 0, exp_cnt, "gl_done");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         LOCKED_IN = (cyc != b + 40);
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      LOCKED_IN = 1'b1;
      if (sb.size() > 0) begin n_checks++; $display("FAIL gl_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_soft();
      int   c;
      int   guard;
      exp_t e;
      c = cyc;
      SOFT_RST_REQ = 1'b1;
      push(c + 1,   4'hF, 0, 0, exp_cnt, "sr_assert");
      push(c + 32,  4'hF, 0, 0, exp_cnt, "sr_hold");
      push(c + 96,  4'hF, 0, 0, exp_cnt, "sr_requal");
      push(c + 97,  4'hE, 0, 0, exp_cnt, "sr_stage0");
      push(c + 145, 4'h0, 1, 0, exp_cnt, "sr_done");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         SOFT_RST_REQ = 1'b0;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      if (sb.size() > 0) begin n_checks++; $display("FAIL sr_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   // Soft request and lock loss seen on the same edge while in RELEASE
   task automatic test_simultaneous();
      int   c;
      int   ex;
      int   guard;
      exp_t e;
      c = cyc;
      SOFT_RST_REQ = 1'b1;
      push(c + 1,  4'hF, 0, 0, exp_cnt, "sim_soft");
      push(c + 97, 4'hE, 0, 0, exp_cnt, "sim_release");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         SOFT_RST_REQ = 1'b0;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      ex = cyc + 3;
      LOCKED_IN = 1'b0;
      push(ex - 1, 4'hE, 0, 0, exp_cnt, "sim_pre");
      exp_cnt++;
      push(ex,     4'hF, 0, 1, exp_cnt, "sim_counted");
      push(ex + 1, 4'hF, 0, 0, exp_cnt, "sim_post");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         SOFT_RST_REQ = (cyc == ex - 1);
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      SOFT_RST_REQ = 1'b0;
      LOCKED_IN = 1'b1;
      // Release timing follows lock re-qualification only, not a soft hold
      push(ex + 66, 4'hF, 0, 0, exp_cnt, "sim_requal");
      push(ex + 67, 4'hE, 0, 0, exp_cnt, "sim_stage0");
      guard = 0;
      while (sb.size() > 0 && guard < 400) begin
         @(negedge WB_CLK); guard++;
         if (sb[0].edge_n == cyc) begin
            e = sb.pop_front(); n_checks++;
            if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
               $display("FAIL %s @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                        e.tag, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
            else n_pass++;
         end
      end
      if (sb.size() > 0) begin n_checks++; $display("FAIL sim_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   // Repeated lock loss right after stage 0 release; count must stick at 255
   task automatic test_saturate();
      int   t;
      int   guard;
      exp_t e;
      for (int i = 0; i < 300; i++) begin
         t = cyc;
         LOCKED_IN = 1'b0;
         push(t + 2, 4'hE, 0, 0, exp_cnt, "sat_pre");
         if (exp_cnt != 255) exp_cnt++;
         push(t + 3, 4'hF, 0, 1, exp_cnt, "sat_pulse");
         guard = 0;
         while (sb.size() > 0 && guard < 400) begin
            @(negedge WB_CLK); guard++;
            if (sb[0].edge_n == cyc) begin
               e = sb.pop_front(); n_checks++;
               if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
                  $display("FAIL %s #%0d @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                           e.tag, i, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
               else n_pass++;
            end
         end
         LOCKED_IN = 1'b1;
         push(t + 68, 4'hF, 0, 0, exp_cnt, "sat_requal");
         push(t + 69, 4'hE, 0, 0, exp_cnt, "sat_stage0");
         guard = 0;
         while (sb.size() > 0 && guard < 400) begin
            @(negedge WB_CLK); guard++;
            if (sb[0].edge_n == cyc) begin
               e = sb.pop_front(); n_checks++;
               if (RST_OUT !== e.rst || SEQ_DONE !== e.done || LOCK_LOST !== e.lost || LOCK_LOSS_CNT !== e.cnt)
                  $display("FAIL %s #%0d @%0d: rst=%h done=%b lost=%b cnt=%0d, required rst=%h done=%b lost=%b cnt=%0d",
                           e.tag, i, cyc, RST_OUT, SEQ_DONE, LOCK_LOST, LOCK_LOSS_CNT, e.rst, e.done, e.lost, e.cnt);
               else n_pass++;
            end
         end
         if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL sat_timeout #%0d: %0d pending, required 0", i, sb.size());
            sb.delete();
            break;
         end
      end
      n_checks++;
      if (LOCK_LOSS_CNT !== 8'd255)
         $display("FAIL sat_final: cnt=%0d, required 255", LOCK_LOSS_CNT);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_lock_loss();
      test_glitch();
      test_soft();
      test_simultaneous();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_rst_sequencer.md
# wb_rst_sequencer

Staged reset sequencer in the Wishbone clock domain, directly downstream of the PCI clock generator. It consumes the DCM/PLL lock indication and the raw Wishbone reset, and releases an ordered set of per-subsystem resets (e.g. WB bus fabric, DMA engine, FIFOs, user logic). The staggered release is spaced a fixed number of cycles apart. On lock loss or a software reset request it re-asserts every stage, re-qualifies lock and repeats the sequence. It also counts lock-loss events for a status register.

## Interface
- NUM_STAGES, 4, number of staged reset outputs (1..8)
- STAGE_GAP, 16, WB_CLK cycles between successive stage releases (≥1)
- LOCK_STABLE, 64, consecutive synchronized-lock-high cycles required before release (≥1)
- SOFT_HOLD, 32, cycles all stages are held after a soft reset request (≥1)

Ports (one clock; reset is synchronous and active-high):
- WB_CLK  in  1  Wishbone clock; all state on rising edge
- WB_RST  in  1  synchronous, active-high reset
- LOCKED_IN  in  1  DCM lock, asynchronous to WB_CLK
- SOFT_RST_REQ  in  1  single-cycle soft reset request from the config register
- RST_OUT  out  NUM_STAGES  active-high stage resets; bit 0 is released first
- SEQ_DONE  out  1  high while all stages are released
- LOCK_LOST  out  1  one-cycle pulse per counted lock loss
- LOCK_LOSS_CNT  out  8  saturating lock-loss count

## Operation
- LOCKED_IN passes through a 2-flop synchronizer giving lock_s. Both flops clear on WB_RST.
- States: IDLE, WAIT_LOCK, RELEASE, RUN, SOFT.
- While WB_RST=1, the following values apply, and these are also the reset values of every output:
  - state=IDLE
  - RST_OUT=all ones, SEQ_DONE=0, LOCK_LOST=0, LOCK_LOSS_CNT=0
  - stable, gap, stage and hold counters are 0
- IDLE → WAIT_LOCK unconditionally on the first edge with WB_RST=0.
- WAIT_LOCK:
  - The stable counter increments on each edge with lock_s=1 and clears on any edge with lock_s=0.
  - On the edge where the counter equals LOCK_STABLE-1 and lock_s=1, the block moves to RELEASE. On that same edge RST_OUT[0] is cleared, stage=0 and gap=0.
- RELEASE:
  - The gap counter increments every cycle.
  - When gap=STAGE_GAP-1, the next stage bit clears, stage increments and gap returns to 0.
  - When the bit for stage NUM_STAGES-1 clears, SEQ_DONE sets on the same edge and the block moves to RUN.
  - With NUM_STAGES=1 the block goes straight from WAIT_LOCK to RUN, and SEQ_DONE sets together with RST_OUT[0] clearing.
- RUN: outputs hold.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next edge: RST_OUT=all ones, SEQ_DONE=0, LOCK_LOST=1 for one cycle, LOCK_LOSS_CNT+1 (saturates at 255), then → WAIT_LOCK with counters cleared.
  - lock_s=0 in WAIT_LOCK or SOFT is not counted. In SOFT it has no effect.
- Soft request (SOFT_RST_REQ=1 in RELEASE or RUN):
  - Next edge: RST_OUT=all ones, SEQ_DONE=0, → SOFT.
  - SOFT holds SOFT_HOLD cycles, then → WAIT_LOCK, where lock must be re-qualified for the full LOCK_STABLE.
  - Requests in IDLE, WAIT_LOCK or SOFT are ignored.
- Simultaneous lock loss and soft request: lock loss wins. The event is counted and the next state is WAIT_LOCK.
- WB_RST mid-sequence: the block returns to the reset values on the next edge, and LOCK_LOSS_CNT clears.

## Timing
- All outputs are registered. There is no combinational path from an input to an output.
- Let E1 be the first edge with WB_RST=0, with LOCKED_IN already high:
  - lock_s is high after E2.
  - RST_OUT[0] falls at E(2+LOCK_STABLE).
  - RST_OUT[k] falls at E(2+LOCK_STABLE+k·STAGE_GAP).
- Defaults: stage 0 at E66, stage 3 and SEQ_DONE at E114.
- Lock-loss response latency: 3 edges from the LOCKED_IN fall (2 synchronizer edges + 1 FSM edge).
- Soft-request response latency: 1 edge.

## Structure
- Shared include wb_rst_seq_defs.vh holds:
  - the state encodings (3-bit localparams ST_IDLE..ST_SOFT)
  - LOCK_CNT_W=8
  - the counter-width function clog2
- Sub-module sync_2ff (parameterized width, synchronous clear) for LOCKED_IN. It is reusable for other CDC control bits.
- The FSM, counters and output registers live in the top module. Target size is about 150–250 lines.

## Test plan
- Power-up, all defaults, LOCKED_IN high, WB_RST released at E0:
  - RST_OUT = 4'b1111 → 4'b1110 at E66, 4'b1100 at E82, 4'b1000 at E98, 4'b0000 at E114.
  - SEQ_DONE rises at E114.
- LOCKED_IN drops for 10 cycles in RUN:
  - RST_OUT=4'hF and LOCK_LOST pulses 3 edges after the fall; LOCK_LOSS_CNT=1.
  - The sequence restarts, with stage 0 released LOCK_STABLE cycles after lock_s returns.
- LOCKED_IN glitches low at stable count 40 in WAIT_LOCK: the stable counter restarts, release slips by 41+ cycles and LOCK_LOSS_CNT is unchanged.
- SOFT_RST_REQ pulse in RUN:
  - All stages assert next edge and are held 32 cycles, then re-qualify for 64 cycles and re-release.
  - LOCK_LOSS_CNT is unchanged.
- SOFT_RST_REQ and lock_s fall on the same cycle in RELEASE: the event is counted (CNT+1), the next state is WAIT_LOCK and SOFT is not entered.
- 300 lock-loss events: LOCK_LOSS_CNT saturates at 255, and LOCK_LOST still pulses on each event.
